// File: rtl/phtime_pkg.sv
// Shared defaults and helpers for the multi-lane phase-time generator.
package phtime_pkg;

    localparam int DEF_FWIDTH   = 27;
    localparam int DEF_PWIDTH   = 27;
    localparam int DEF_TWIDTH   = 27;
    localparam int DEF_NLANE    = 4;
    localparam int DEF_MULT_LAT = 3;

    function automatic int clog2(input int value);
        int r;
        for (r = 0; (1 << r) < value; r++) begin
        end
        return r;
    endfunction

    // Lowest bit of lane k inside the packed phase bus.
    function automatic int lane_lsb(input int lane, input int pwidth);
        return lane * pwidth;
    endfunction

endpackage

// File: rtl/phtime_mult.sv
// Truncating FWIDTH x TWIDTH -> PWIDTH multiplier with MULT_LAT register stages.
module phtime_mult #(
    parameter int FWIDTH   = 27,
    parameter int TWIDTH   = 27,
    parameter int PWIDTH   = 27,
    parameter int MULT_LAT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FWIDTH-1:0] a,
    input  logic [TWIDTH-1:0] b,
    output logic [PWIDTH-1:0] p
);

    logic [PWIDTH-1:0] stage [MULT_LAT];

    // Only the low PWIDTH bits matter, so the product is formed at that width.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MULT_LAT; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= PWIDTH'(a) * PWIDTH'(b);
            for (int i = 1; i < MULT_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign p = stage[MULT_LAT-1];

endmodule

// File: rtl/phtime_lanes.sv
// NLANE-wide phase generator: phase_k = freq*(NLANE*n + k) + phoff, with shadowed config.
module phtime_lanes
    import phtime_pkg::*;
#(
    parameter int FWIDTH   = DEF_FWIDTH,
    parameter int PWIDTH   = DEF_PWIDTH,
    parameter int TWIDTH   = DEF_TWIDTH,
    parameter int NLANE    = DEF_NLANE,
    parameter int MULT_LAT = DEF_MULT_LAT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [FWIDTH-1:0]       freq,
    input  logic [PWIDTH-1:0]       phoff,
    input  logic                    cfg_stb,
    input  logic                    sync,
    input  logic                    en,
    output logic [NLANE*PWIDTH-1:0] phase,
    output logic                    valid,
    output logic                    running
);

    localparam int LOGN = clog2(NLANE);
    localparam int BUSW = NLANE * PWIDTH;

    if (NLANE < 1 || NLANE > 16 || (1 << LOGN) != NLANE) begin : g_bad_nlane
        $error("phtime_lanes: NLANE must be a power of two in 1..16");
    end
    if (TWIDTH + LOGN < PWIDTH) begin : g_bad_twidth
        $error("phtime_lanes: TWIDTH + log2(NLANE) must be >= PWIDTH");
    end
    if (MULT_LAT < 1) begin : g_bad_lat
        $error("phtime_lanes: MULT_LAT must be >= 1");
    end

    logic [FWIDTH-1:0] sh_freq, act_freq, new_freq;
    logic [PWIDTH-1:0] sh_phoff, new_phoff;
    logic [BUSW-1:0]   c_bus, c_next;
    logic [TWIDTH-1:0] n;
    logic              launch;

    logic              l_tag;
    logic [TWIDTH-1:0] l_n;
    logic [FWIDTH-1:0] l_f;
    logic [BUSW-1:0]   l_c;

    logic [PWIDTH-1:0] prod;
    logic              tag_pipe [MULT_LAT];
    logic [BUSW-1:0]   c_pipe   [MULT_LAT];
    logic [BUSW-1:0]   phase_next;

    assign new_freq  = cfg_stb ? freq  : sh_freq;
    assign new_phoff = cfg_stb ? phoff : sh_phoff;
    assign launch    = running && en && !sync;

    for (genvar k = 0; k < NLANE; k++) begin : g_lane
        assign c_next[lane_lsb(k, PWIDTH) +: PWIDTH] =
            PWIDTH'(new_freq) * PWIDTH'(k) + new_phoff;
        assign phase_next[lane_lsb(k, PWIDTH) +: PWIDTH] =
            (prod << LOGN) + c_pipe[MULT_LAT-1][lane_lsb(k, PWIDTH) +: PWIDTH];
    end

    // Shadow/active config and the time counter; sync restarts the count and never launches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_freq  <= '0;
            sh_phoff <= '0;
            act_freq <= '0;
            c_bus    <= '0;
            n        <= '0;
            running  <= 1'b0;
        end else begin
            if (cfg_stb) begin
                sh_freq  <= freq;
                sh_phoff <= phoff;
            end
            if (sync) begin
                act_freq <= new_freq;
                c_bus    <= c_next;
                n        <= '0;
                running  <= 1'b1;
            end else if (launch) begin
                n <= n + TWIDTH'(1);
            end
        end
    end

    // Each launched word carries its own freq and lane constants so a re-sync cannot corrupt it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l_tag <= 1'b0;
            l_n   <= '0;
            l_f   <= '0;
            l_c   <= '0;
        end else begin
            l_tag <= launch;
            if (launch) begin
                l_n <= n;
                l_f <= act_freq;
                l_c <= c_bus;
            end
        end
    end

    phtime_mult #(
        .FWIDTH  (FWIDTH),
        .TWIDTH  (TWIDTH),
        .PWIDTH  (PWIDTH),
        .MULT_LAT(MULT_LAT)
    ) u_mult (
        .clk  (clk),
        .reset(reset),
        .a    (l_f),
        .b    (l_n),
        .p    (prod)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MULT_LAT; i++) begin
                tag_pipe[i] <= 1'b0;
                c_pipe[i]   <= '0;
            end
            phase <= '0;
            valid <= 1'b0;
        end else begin
            tag_pipe[0] <= l_tag;
            c_pipe[0]   <= l_c;
            for (int i = 1; i < MULT_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
                c_pipe[i]   <= c_pipe[i-1];
            end
            valid <= tag_pipe[MULT_LAT-1];
            if (tag_pipe[MULT_LAT-1]) begin
                phase <= phase_next;
            end
        end
    end

endmodule
